// File: rtl/pause_ctrl.sv
// pause_ctrl
//   Pause controller for the wire-cutting game. It sits between the
//   wire-selection logic and the game timer/display. Its pause output gates
//   the countdown.
//   - A new wire_to_cut freezes the game.
//   - A change of the displayed colour releases it.
//   - A player force-pause holds the game frozen.
//   - An optional timeout resumes the game automatically.
//   - A saturating counter records how many times the game was paused.
//
// Parameters
//   WIRE_W      width of wire_to_cut
//   COLOUR_W    width of curr_colour
//   TIMEOUT_CYC cycles spent in PAUSED before auto-resume (0 = no timeout)
//   CNT_W       width of the timeout counter (2^CNT_W > TIMEOUT_CYC)
//
// Ports
//   clk           system clock; all inputs are synchronous to it
//   reset         synchronous, active-high reset
//   wire_to_cut   current target wire from the game logic
//   curr_colour   colour currently shown to the player
//   force_pause   level input; while high, the controller stays PAUSED
//   pause         1 = game frozen (registered)
//   running       always the inverse of pause (registered)
//   timeout_pulse one-cycle strobe when the timeout resumes the game
//   pause_count   number of RUNNING->PAUSED transitions, saturates at 255
module pause_ctrl #(
  parameter int WIRE_W      = 3,
  parameter int COLOUR_W    = 3,
  parameter int TIMEOUT_CYC = 0,
  parameter int CNT_W       = 27
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIRE_W-1:0]   wire_to_cut,
  input  logic [COLOUR_W-1:0] curr_colour,
  input  logic                force_pause,
  output logic                pause,
  output logic                running,
  output logic                timeout_pulse,
  output logic [7:0]          pause_count
);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  // Last count value before release. It is only meaningful when TMO_EN is set.
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  state_t              state_reg;
  logic [WIRE_W-1:0]   wire_q;
  logic [COLOUR_W-1:0] colour_q;
  logic [CNT_W-1:0]    tmo_cnt;
  logic                wire_chg;
  logic                colour_chg;

  // Compare each input against its value at the previous edge.
  // Reset loads the current inputs into wire_q and colour_q. This prevents a
  // false change from being seen on the first edge after reset.
  assign wire_chg   = (wire_to_cut != wire_q);
  assign colour_chg = (curr_colour != colour_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= PAUSED;
      pause         <= 1'b1;
      running       <= 1'b0;
      timeout_pulse <= 1'b0;
      pause_count   <= 8'd0;
      tmo_cnt       <= '0;
      wire_q        <= wire_to_cut;
      colour_q      <= curr_colour;
    end else begin
      wire_q        <= wire_to_cut;
      colour_q      <= curr_colour;
      timeout_pulse <= 1'b0;

      if (state_reg == PAUSED) begin
        // Check events in priority order.
        // A pause request beats a colour change, and a colour change beats
        // the timeout.
        if (force_pause || wire_chg) begin
          tmo_cnt <= '0;
        end else if (colour_chg) begin
          state_reg <= RUNNING;
          pause     <= 1'b0;
          running   <= 1'b1;
          tmo_cnt   <= '0;
        end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
          state_reg     <= RUNNING;
          pause         <= 1'b0;
          running       <= 1'b1;
          timeout_pulse <= 1'b1;
          tmo_cnt       <= '0;
        end else if (TMO_EN) begin
          tmo_cnt <= tmo_cnt + 1'b1;
        end
      end else begin
        // A colour change on its own does nothing while RUNNING.
        if (wire_chg || force_pause) begin
          state_reg <= PAUSED;
          pause     <= 1'b1;
          running   <= 1'b0;
          tmo_cnt   <= '0;
          if (pause_count != 8'hFF) begin
            pause_count <= pause_count + 8'd1;
          end
        end
      end
    end
  end

endmodule
